// File: rtl/tdm_demux8.sv
// -----------------------------------------------------------------------------
// tdm_demux8
//   Receive end of an 8:1 time-division-multiplexed serial link. Bits arrive
//   one per accepted clock (din_valid=1). A bit with start=1 marks slot 0 of a
//   frame. The block collects slots 0..7 in an internal shadow register. When
//   slot 7 arrives, it transfers the completed frame to the parallel output Q.
//
// Parameters
//   MSB_FIRST  0: slot k lands in Q[k]; 1: slot k lands in Q[7-k]
//
// Ports
//   clk        in   rising-edge clock, sole domain
//   rst_n      in   asynchronous active-low reset
//   start      in   frame sync, qualified by din_valid; marks slot 0
//   din        in   serial data bit
//   din_valid  in   qualifier for din/start
//   S          out  [2:0] next slot to be written (registered)
//   Q          out  [7:0] last completed frame (registered, holds)
//   q_valid    out  one-cycle pulse: Q was updated
//   busy       out  1 while a frame is partially received
//   frame_err  out  one-cycle pulse: partial frame aborted by resync
// -----------------------------------------------------------------------------
module tdm_demux8 #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       din,
    input  logic       din_valid,
    output logic [2:0] S,
    output logic [7:0] Q,
    output logic       q_valid,
    output logic       busy,
    output logic       frame_err
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] s_nxt;
    logic [7:0] shadow, shadow_nxt;
    logic [7:0] q_nxt;
    logic       q_valid_nxt;
    logic       frame_err_nxt;

    // Bit position inside shadow/Q that a given slot occupies.
    function automatic logic [2:0] slot_pos(input logic [2:0] slot);
        return MSB_FIRST ? (3'd7 - slot) : slot;
    endfunction

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_nxt     = state;
        s_nxt         = S;
        shadow_nxt    = shadow;
        q_nxt         = Q;
        q_valid_nxt   = 1'b0;
        frame_err_nxt = 1'b0;

        if (din_valid) begin
            unique case (state)
                IDLE: begin
                    // Bits outside a frame are dropped until a sync arrives.
                    if (start) begin
                        shadow_nxt[slot_pos(3'd0)] = din;
                        s_nxt                      = 3'd1;
                        state_nxt                  = SHIFT;
                    end
                end

                SHIFT: begin
                    if (start) begin
                        // Resync: abandon the partial frame, this bit is slot 0.
                        // Stale shadow bits are harmless because a full frame
                        // rewrites every position before it reaches Q.
                        shadow_nxt[slot_pos(3'd0)] = din;
                        s_nxt                      = 3'd1;
                        frame_err_nxt              = 1'b1;
                    end else begin
                        shadow_nxt[slot_pos(S)] = din;
                        if (S == 3'd7) begin
                            // NOTE: blocking assignment inside always_comb makes
                            // the updated shadow_nxt (with slot 7) visible here,
                            // so Q captures the completed frame on this edge.
                            q_nxt       = shadow_nxt;
                            q_valid_nxt = 1'b1;
                            s_nxt       = 3'd0;
                            state_nxt   = IDLE;
                        end else begin
                            s_nxt = S + 3'd1;
                        end
                    end
                end

                default: state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: the shadow register is only 8 flops, so it is reset together with
    // the rest; a large memory would normally be left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            S         <= 3'd0;
            shadow    <= 8'h00;
            Q         <= 8'h00;
            q_valid   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state     <= state_nxt;
            S         <= s_nxt;
            shadow    <= shadow_nxt;
            Q         <= q_nxt;
            q_valid   <= q_valid_nxt;
            frame_err <= frame_err_nxt;
        end
    end

    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_tdm_demux8.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux8
//   Drives one serial stream into two instances (MSB_FIRST=0 and 1). Expected
//   frames are pushed into per-instance queues before stimulus; a monitor pops
//   and compares whenever q_valid is seen. Inputs change on the falling edge,
//   outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_tdm_demux8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;

    logic [2:0] s0, s1;
    logic [7:0] q0, q1;
    logic       qv0, qv1, busy0, busy1, fe0, fe1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int err_exp  = 0;
    int err_seen0 = 0;
    int err_seen1 = 0;

    logic [7:0] exp0[$];
    logic [7:0] exp1[$];
    int         qv_times0[$];

    always #5 clk = ~clk;

    tdm_demux8 #(.MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .din(din), .din_valid(din_valid),
        .S(s0), .Q(q0), .q_valid(qv0), .busy(busy0), .frame_err(fe0)
    );

    tdm_demux8 #(.MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .din(din), .din_valid(din_valid),
        .S(s1), .Q(q1), .q_valid(qv1), .busy(busy1), .frame_err(fe1)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        cyc++;
        if (qv0) begin
            qv_times0.push_back(cyc);
            check("excl0", {7'd0, fe0}, 8'h00);
            if (exp0.size() == 0) check("q0_unexpected_qvalid", {7'd0, qv0}, 8'h00);
            else check("q0_frame", q0, exp0.pop_front());
        end
        if (qv1) begin
            check("excl1", {7'd0, fe1}, 8'h00);
            if (exp1.size() == 0) check("q1_unexpected_qvalid", {7'd0, qv1}, 8'h00);
            else check("q1_frame", q1, exp1.pop_front());
        end
        if (fe0) err_seen0++;
        if (fe1) err_seen1++;
    end

    task automatic wait_neg();
        @(negedge clk);
    endtask

    task automatic drive(input logic st, input logic d, input logic v);
        start     = st;
        din       = d;
        din_valid = v;
    endtask

    task automatic check_s(input string name, input logic [2:0] exp_s, input logic exp_busy);
        check({name, "_s0"}, {5'd0, s0}, {5'd0, exp_s});
        check({name, "_s1"}, {5'd0, s1}, {5'd0, exp_s});
        check({name, "_busy0"}, {7'd0, busy0}, {7'd0, exp_busy});
        check({name, "_busy1"}, {7'd0, busy1}, {7'd0, exp_busy});
    endtask

    // Sends n bits, slot k carrying slots[k]; start=1 on the first.
    // gaps[k]=1 inserts 3 invalid cycles after slot k.
    task automatic send_frame(input logic [7:0] slots, input int n, input logic [7:0] gaps);
        for (int k = 0; k < n; k++) begin
            wait_neg();
            if (k > 0) check_s("slot", 3'(k), 1'b1);
            drive(k == 0, slots[k], 1'b1);
            if (gaps[k]) begin
                for (int g = 0; g < 3; g++) begin
                    wait_neg();
                    check_s("gap", 3'(k + 1), 1'b1);
                    drive(1'b0, 1'b1, 1'b0);
                end
            end
        end
    endtask

    // After a complete frame: S back to 0, not busy, q_valid only one cycle.
    task automatic frame_tail();
        wait_neg();
        check_s("tail", 3'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        wait_neg();
        check("qv0_single", {7'd0, qv0}, 8'h00);
        check("qv1_single", {7'd0, qv1}, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        // Reset values before any clock edge.
        #3;
        check_s("reset", 3'd0, 1'b0);
        check("reset_q0", q0, 8'h00);
        check("reset_q1", q1, 8'h00);
        check("reset_fe0", {7'd0, fe0}, 8'h00);
        check("reset_qv0", {7'd0, qv0}, 8'h00);
        repeat (2) wait_neg();
        rst_n = 1'b1;

        // Bits with start=0 in IDLE are discarded.
        for (int i = 0; i < 3; i++) begin
            wait_neg();
            drive(1'b0, 1'b1, 1'b1);
        end
        wait_neg();
        check_s("idle_ignore", 3'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);

        // Plain frame 1,0,1,1,0,0,1,0.
        exp0.push_back(8'h4D); exp1.push_back(8'hB2);
        send_frame(8'h4D, 8, 8'h00);
        frame_tail();

        // Same frame with 3-cycle gaps after slots 2 and 6.
        exp0.push_back(8'h4D); exp1.push_back(8'hB2);
        send_frame(8'h4D, 8, 8'b0100_0100);
        frame_tail();

        // Resync: 4 bits, then a new start carrying A5.
        send_frame(8'h0B, 4, 8'h00);
        wait_neg();
        check_s("partial", 3'd4, 1'b1);
        check("partial_q0_held", q0, 8'h4D);
        drive(1'b0, 1'b0, 1'b0);
        err_exp++;
        exp0.push_back(8'hA5); exp1.push_back(8'hA5);
        send_frame(8'hA5, 8, 8'h00);
        frame_tail();

        // Back-to-back frames 0F then F0.
        exp0.push_back(8'h0F); exp1.push_back(8'hF0);
        exp0.push_back(8'hF0); exp1.push_back(8'h0F);
        send_frame(8'h0F, 8, 8'h00);
        send_frame(8'hF0, 8, 8'h00);
        frame_tail();
        check("b2b_spacing", 8'(qv_times0[$] - qv_times0[$-1]), 8'd8);

        // Frames 1,0,0,0,0,0,0,1 and 1,0,1,0,0,0,0,0.
        exp0.push_back(8'h81); exp1.push_back(8'h81);
        exp0.push_back(8'h05); exp1.push_back(8'hA0);
        send_frame(8'h81, 8, 8'h00);
        send_frame(8'h05, 8, 8'h00);
        frame_tail();

        // Asynchronous reset mid-frame at S=5.
        send_frame(8'h1F, 5, 8'h00);
        wait_neg();
        check_s("pre_reset", 3'd5, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_s("async_reset", 3'd0, 1'b0);
        check("async_reset_q0", q0, 8'h00);
        check("async_reset_q1", q1, 8'h00);
        check("async_reset_fe0", {7'd0, fe0}, 8'h00);
        check("async_reset_qv1", {7'd0, qv1}, 8'h00);
        drive(1'b0, 1'b0, 1'b0);
        wait_neg();
        rst_n = 1'b1;

        // First frame after reset.
        exp0.push_back(8'h4D); exp1.push_back(8'hB2);
        send_frame(8'h4D, 8, 8'h00);
        frame_tail();

        repeat (3) wait_neg();
        check("exp0_drained", 8'(exp0.size()), 8'd0);
        check("exp1_drained", 8'(exp1.size()), 8'd0);
        check("frame_err0_count", 8'(err_seen0), 8'(err_exp));
        check("frame_err1_count", 8'(err_seen1), 8'(err_exp));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
